fp_mult_core: RTL and testbench

FP_MULT_CORE -- requirements
Module: fp_mult_core

---
 rtl/rnd_enum.sv | 15 +
 rtl/round_mult.sv | 52 +++++
 rtl/fp_mult_core.sv | 135 +++++++++++++
 tb/tb_fp_mult_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnd_enum.sv
// Shared rounding-mode encoding and FP32 constants for the multiply datapath.
package rnd_enum;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } rnd_t;

    localparam logic signed [9:0] EXP_BIAS = 10'sd127;

endpackage

// File: rtl/round_mult.sv
// Combinational rounding of a normalized product: increment, renormalize, pack, flag.
module round_mult
    import rnd_enum::*;
#(
    parameter int FRAC_W = 23
) (
    input  logic                    sign,
    input  logic signed [9:0]       exp_in,
    input  logic [FRAC_W-1:0]       frac,
    input  logic                    g,
    input  logic                    s,
    input  rnd_t                    rnd,
    output logic [FRAC_W+8:0]       z,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    logic              inc;
    logic [FRAC_W:0]   sum;
    logic [FRAC_W-1:0] frac_r;
    logic signed [9:0] exp_f;

    always_comb begin
        inc = 1'b0;
        case (rnd)
            IEEE_near: inc = g & (s | frac[0]);
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = (g | s) & ~sign;
            IEEE_ninf: inc = (g | s) & sign;
            near_up:   inc = g;
            away_zero: inc = g | s;
            default:   inc = 1'b0;
        endcase

        sum = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
        // Carry out of the fraction means the significand reached 2.0
        if (sum[FRAC_W]) begin
            frac_r = '0;
            exp_f  = exp_in + 10'sd1;
        end else begin
            frac_r = sum[FRAC_W-1:0];
            exp_f  = exp_in;
        end

        overflow  = (exp_f >= 10'sd255);
        underflow = (exp_f <= 10'sd0);
        inexact   = g | s;
        z         = {sign, exp_f[7:0], frac_r};
    end

endmodule

// File: rtl/fp_mult_core.sv
// Sequential FP32 significand multiplier: radix-2 shift-add, normalize, round.
module fp_mult_core
    import rnd_enum::*;
#(
    parameter int MANT_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  rnd_t        rnd,
    output logic        busy,
    output logic        done,
    output logic [31:0] a_q,
    output logic [31:0] b_q,
    output rnd_t        rnd_q,
    output logic [31:0] z_calc,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    localparam int PW     = 2 * MANT_W;
    localparam int FRAC_W = MANT_W - 1;
    localparam int CW     = $clog2(MANT_W);

    typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      mcand;
    logic [MANT_W-1:0]  mplier;
    logic [PW-1:0]      prod;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [FRAC_W-1:0]  frac_n;
    logic               g_n, s_n;

    logic [31:0]        rz;
    logic               r_ov, r_un, r_ix;

    assign busy = (state == MULT) || (state == NORM) || (state == ROUND);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MULT;
            MULT:    if (cnt == CW'(MANT_W - 1)) state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rnd_q     <= IEEE_near;
            z_calc    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            frac_n    <= '0;
            g_n       <= 1'b0;
            s_n       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    a_q    <= a;
                    b_q    <= b;
                    rnd_q  <= rnd;
                    // Hidden bit is forced to 1 regardless of exponent field
                    mcand  <= {{MANT_W{1'b0}}, 1'b1, a[FRAC_W-1:0]};
                    mplier <= {1'b1, b[FRAC_W-1:0]};
                    prod   <= '0;
                    cnt    <= '0;
                    sign_r <= a[31] ^ b[31];
                    exp_r  <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - EXP_BIAS;
                end
                MULT: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                NORM: begin
                    // Product lies in [1,4); bit PW-1 set means it is >= 2
                    if (prod[PW-1]) begin
                        frac_n <= prod[PW-2 -: FRAC_W];
                        g_n    <= prod[PW-MANT_W-1];
                        s_n    <= |prod[PW-MANT_W-2:0];
                        exp_r  <= exp_r + 10'sd1;
                    end else begin
                        frac_n <= prod[PW-3 -: FRAC_W];
                        g_n    <= prod[PW-MANT_W-2];
                        s_n    <= |prod[PW-MANT_W-3:0];
                    end
                end
                ROUND: begin
                    z_calc    <= rz;
                    overflow  <= r_ov;
                    underflow <= r_un;
                    inexact   <= r_ix;
                end
                default: ;
            endcase
        end
    end

    round_mult #(.FRAC_W(FRAC_W)) u_round (
        .sign      (sign_r),
        .exp_in    (exp_r),
        .frac      (frac_n),
        .g         (g_n),
        .s         (s_n),
        .rnd       (rnd_q),
        .z         (rz),
        .overflow  (r_ov),
        .underflow (r_un),
        .inexact   (r_ix)
    );

endmodule

// File: tb/tb_fp_mult_core.sv
// Self-checking bench for fp_mult_core against an arithmetic reference model.
module tb_fp_mult_core;
    import rnd_enum::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b;
    rnd_t        rnd;
    logic        busy, done;
    logic [31:0] a_q, b_q, z_calc;
    rnd_t        rnd_q;
    logic        overflow, underflow, inexact;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_mult_core #(.MANT_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .rnd(rnd),
        .busy(busy), .done(done), .a_q(a_q), .b_q(b_q), .rnd_q(rnd_q),
        .z_calc(z_calc), .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    // Exact product via 64-bit integers, then IEEE-style rounding of the remainder
    function automatic void model(input logic [31:0] xa, input logic [31:0] xb, input rnd_t r,
                                  output logic [31:0] z, output logic ov, output logic un,
                                  output logic ix);
        longint unsigned ma, mb, p, q, rem, half;
        int e, sh;
        logic sg, g, s, inc;
        logic [31:0] ev;
        ma = {40'd0, 1'b1, xa[22:0]};
        mb = {40'd0, 1'b1, xb[22:0]};
        p  = ma * mb;
        sg = xa[31] ^ xb[31];
        e  = int'(xa[30:23]) + int'(xb[30:23]) - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        q    = p >> sh;
        rem  = p % (64'd1 << sh);
        half = 64'd1 << (sh - 1);
        g    = (rem >= half);
        s    = ((rem % half) != 0);
        case (r)
            IEEE_near: inc = g & (s | q[0]);
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = (g | s) & ~sg;
            IEEE_ninf: inc = (g | s) & sg;
            near_up:   inc = g;
            default:   inc = g | s;
        endcase
        q = q + {63'd0, inc};
        if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
        ov = (e >= 255);
        un = (e <= 0);
        ix = g | s;
        ev = 32'(e);
        z  = {sg, ev[7:0], q[22:0]};
    endfunction

    // Drives one operation; returns observed latency, results and the done level one cycle later
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input rnd_t tr,
                          output int lat, output logic [31:0] z, output logic ov,
                          output logic un, output logic ix, output logic done_after);
        a = ta; b = tb_; rnd = tr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; rnd = rnd_t'($urandom_range(0, 5));
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        z = z_calc; ov = overflow; un = underflow; ix = inexact;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 32'h3FC00000; b = 32'h40000000; rnd = IEEE_pinf;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (a_q !== 32'h0 || b_q !== 32'h0 || z_calc !== 32'h0) begin
            failures++; $display("FAIL reset_data a_q=%h b_q=%h z=%h want 0", a_q, b_q, z_calc);
        end
        checks++;
        if ({overflow, underflow, inexact} !== 3'b000 || rnd_q !== IEEE_near) begin
            failures++; $display("FAIL reset_flags flags=%b rnd_q=%0d want 000 %0d",
                                 {overflow, underflow, inexact}, rnd_q, IEEE_near);
        end
        start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle busy=%b want 0", busy);
        end
    endtask

    typedef struct {
        logic [31:0] a, b;
        rnd_t        r;
        logic [31:0] z;
        logic [2:0]  fl;   // {overflow, underflow, inexact}
    } vec_t;

    task automatic test_directed();
        vec_t v[10];
        int lat;
        logic [31:0] z;
        logic ov, un, ix, da;
        v[0] = '{32'h3FC00000, 32'h40000000, IEEE_near, 32'h40400000, 3'b000};
        v[1] = '{32'h3F800001, 32'h3F800001, IEEE_near, 32'h3F800002, 3'b001};
        v[2] = '{32'h3F800001, 32'h3F800001, away_zero, 32'h3F800003, 3'b001};
        v[3] = '{32'h3F800001, 32'h3F800001, IEEE_pinf, 32'h3F800003, 3'b001};
        v[4] = '{32'h3F800001, 32'h3F800001, IEEE_zero, 32'h3F800002, 3'b001};
        v[5] = '{32'h7F000000, 32'h40000000, IEEE_near, 32'h7F800000, 3'b100};
        v[6] = '{32'h00800000, 32'h3F000000, IEEE_near, 32'h00000000, 3'b010};
        v[7] = '{32'hBF800000, 32'h3F800000, IEEE_near, 32'hBF800000, 3'b000};
        v[8] = '{32'hBF800001, 32'h3F800001, IEEE_ninf, 32'hBF800003, 3'b001};
        v[9] = '{32'hBF800001, 32'h3F800001, near_up,   32'hBF800002, 3'b001};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].a, v[i].b, v[i].r, lat, z, ov, un, ix, da);
            checks++;
            if (lat !== 26) begin
                failures++; $display("FAIL dir%0d_latency got=%0d want=26", i, lat);
            end
            checks++;
            if (z !== v[i].z || {ov, un, ix} !== v[i].fl) begin
                failures++; $display("FAIL dir%0d_result z=%h fl=%b want z=%h fl=%b",
                                     i, z, {ov, un, ix}, v[i].z, v[i].fl);
            end
            checks++;
            if (da !== 1'b0 || a_q !== v[i].a || b_q !== v[i].b || rnd_q !== v[i].r) begin
                failures++; $display("FAIL dir%0d_capture done_after=%b a_q=%h b_q=%h rnd_q=%0d",
                                     i, da, a_q, b_q, rnd_q);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] ra, rb, z, ez;
        logic ov, un, ix, eov, eun, eix, da;
        rnd_t rr;
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i < 30) begin
                // Keep half the exponents near the bias for mostly normal results
                ra[30:23] = 8'($urandom_range(100, 150));
                rb[30:23] = 8'($urandom_range(100, 150));
            end
            rr = rnd_t'($urandom_range(0, 5));
            model(ra, rb, rr, ez, eov, eun, eix);
            run_op(ra, rb, rr, lat, z, ov, un, ix, da);
            checks++;
            if (z !== ez || {ov, un, ix} !== {eov, eun, eix} || lat !== 26) begin
                failures++;
                $display("FAIL rand%0d a=%h b=%h rnd=%0d z=%h fl=%b lat=%0d want z=%h fl=%b lat=26",
                         i, ra, rb, rr, z, {ov, un, ix}, lat, ez, {eov, eun, eix});
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] z, ez;
        logic ov, un, ix, eov, eun, eix, da;
        run_op(32'h3FC00000, 32'h40000000, IEEE_near, lat, z, ov, un, ix, da);
        model(32'h3F800001, 32'h3F800001, away_zero, ez, eov, eun, eix);
        run_op(32'h3F800001, 32'h3F800001, away_zero, lat, z, ov, un, ix, da);
        checks++;
        if (lat !== 26 || z !== ez || {ov, un, ix} !== {eov, eun, eix}) begin
            failures++; $display("FAIL b2b_second lat=%0d z=%h fl=%b want 26 %h %b",
                                 lat, z, {ov, un, ix}, ez, {eov, eun, eix});
        end
    endtask

    task automatic test_ignore_start();
        int lat, ndone;
        a = 32'h3FC00000; b = 32'h40000000; rnd = IEEE_near; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        a = 32'h12345678; b = 32'h0BADF00D; rnd = IEEE_zero; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (a_q !== 32'h3FC00000 || b_q !== 32'h40000000 || rnd_q !== IEEE_near) begin
            failures++; $display("FAIL ignore_capture a_q=%h b_q=%h rnd_q=%0d want 3fc00000 40000000 0",
                                 a_q, b_q, rnd_q);
        end
        lat = 6; ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            if (done && ndone == 1) begin
                checks++;
                if (lat !== 26 || z_calc !== 32'h40400000) begin
                    failures++; $display("FAIL ignore_result lat=%0d z=%h want 26 40400000", lat, z_calc);
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (ndone !== 1) begin
            failures++; $display("FAIL ignore_single_done count=%0d want 1", ndone);
        end
    endtask

    task automatic test_abort();
        int ndone, lat;
        logic [31:0] z;
        logic ov, un, ix, da;
        a = 32'h40000000; b = 32'h40400000; rnd = IEEE_near; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || a_q !== 32'h0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_state busy=%b a_q=%h done=%b want 0 0 0", busy, a_q, done);
        end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++; $display("FAIL abort_no_done active_cycles=%0d want 0", ndone);
        end
        run_op(32'h40000000, 32'h40400000, IEEE_near, lat, z, ov, un, ix, da);
        checks++;
        if (lat !== 26 || z !== 32'h40C00000 || {ov, un, ix} !== 3'b000) begin
            failures++; $display("FAIL abort_fresh lat=%0d z=%h fl=%b want 26 40c00000 000",
                                 lat, z, {ov, un, ix});
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; a = '0; b = '0; rnd = IEEE_near;
        #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
